pi_controller: RTL and testbench

- Priority-interrupt (PI) scheduler for the KV10 CPU.
- Arbitrates seven interrupt levels (1 highest, 7 lowest) between device requests and program requests, and presents the winning level and its vector address to the CPU.
- Sequences the interrupt-instruction cycle using the jump/skip outcome reported by the CPU (derived from decode's int_jump/int_skip), holding or dismissing levels.
- Executes CONO PI commands and sources the CONI PI status word.

---
 rtl/pi_controller_if.sv | 29 ++
 rtl/pi_controller.sv | 185 ++++++++++++++++++
 tb/tb_pi_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pi_controller_if.sv
// Bus between the KV10 CPU and the priority-interrupt controller:
// device requests, CONO/CONI PI, and the interrupt-cycle handshake.
interface pi_controller_if #(
    parameter int ADDR_W = 18
);
    logic [1:7]        dev_req;
    logic              cono;
    logic [18:35]      cono_e;
    logic              dismiss;
    logic              cpu_ack;
    logic              int_done;
    logic              int_hold;
    logic              int_second;
    logic              pi_req;
    logic [0:2]        pi_level;
    logic [ADDR_W-1:0] pi_addr;
    logic              pi_busy;
    logic [0:35]       coni;

    modport master (
        output dev_req, cono, cono_e, dismiss, cpu_ack, int_done, int_hold, int_second,
        input  pi_req, pi_level, pi_addr, pi_busy, coni
    );

    modport slave (
        input  dev_req, cono, cono_e, dismiss, cpu_ack, int_done, int_hold, int_second,
        output pi_req, pi_level, pi_addr, pi_busy, coni
    );
endinterface

// File: rtl/pi_controller.sv
// KV10 priority-interrupt scheduler: seven-level arbitration, interrupt-cycle sequencing, CONO/CONI PI.
// Program requests (CONO bits 22/24, CONI preq field) exist only when KV10_PI_PROGREQ_EN is defined.
module pi_controller #(
    parameter int INT_BASE = 'o40,
    parameter int ADDR_W   = 18
) (
    input logic           clk,
    input logic           reset,
    pi_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, CYC1, CYC2} state_t;

    state_t            state, state_nxt;
    logic [1:7]        on_q, on_nxt;
    logic [1:7]        held_q, held_nxt;
    logic [1:7]        preq_q, preq_nxt;
    logic              act_q, act_nxt;
    logic [2:0]        lvl_q, lvl_nxt;
    logic              req_q, req_nxt;
    logic              busy_q, busy_nxt;
    logic [2:0]        level_q, level_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;

    logic [1:7]        sel;
    logic [1:7]        pending;
    logic [2:0]        winner;
    logic              blocked;
    logic              found;
    logic [ADDR_W-1:0] win_addr;
    logic              unused_cono_bits;

    assign sel      = bus.cono_e[29:35];
    assign pending  = (bus.dev_req | preq_q) & on_q & {7{act_q}};
    assign win_addr = ADDR_W'(INT_BASE) + ADDR_W'({winner, 1'b0});
    assign unused_cono_bits = ^{bus.cono_e[18:22], bus.cono_e[24]};

    // A held level masks itself and every lower-priority level.
    always_comb begin
        winner  = 3'd0;
        blocked = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            blocked = blocked | held_q[n];
            if (!blocked && pending[n] && winner == 3'd0)
                winner = 3'(n);
        end
    end

    always_comb begin
        state_nxt = state;
        on_nxt    = on_q;
        act_nxt   = act_q;
        held_nxt  = held_q;
        preq_nxt  = preq_q;
        lvl_nxt   = lvl_q;
        req_nxt   = req_q;
        busy_nxt  = busy_q;
        level_nxt = level_q;
        addr_nxt  = addr_q;
        found     = 1'b0;

        if (bus.dismiss) begin
            for (int n = 1; n <= 7; n++) begin
                if (!found && held_q[n]) begin
                    held_nxt[n] = 1'b0;
                    found       = 1'b1;
                end
            end
        end

        case (state)
            IDLE: begin
                if (winner != 3'd0) begin
                    req_nxt   = 1'b1;
                    level_nxt = winner;
                    addr_nxt  = win_addr;
                    state_nxt = REQ;
                end else begin
                    req_nxt   = 1'b0;
                    level_nxt = 3'd0;
                end
            end
            REQ: begin
                if (bus.cpu_ack && req_q) begin
                    lvl_nxt   = level_q;
`ifdef KV10_PI_PROGREQ_EN
                    preq_nxt[level_q] = 1'b0;
`endif
                    req_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = CYC1;
                end else if (winner != 3'd0) begin
                    req_nxt   = 1'b1;
                    level_nxt = winner;
                    addr_nxt  = win_addr;
                end else begin
                    req_nxt   = 1'b0;
                    level_nxt = 3'd0;
                    state_nxt = IDLE;
                end
            end
            CYC1: begin
                if (bus.int_done) begin
                    if (bus.int_hold) begin
                        held_nxt[lvl_q] = 1'b1;
                        busy_nxt        = 1'b0;
                        state_nxt       = IDLE;
                    end else if (bus.int_second) begin
                        addr_nxt  = addr_q + 1'b1;
                        state_nxt = CYC2;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            CYC2: begin
                if (bus.int_done) begin
                    if (bus.int_hold)
                        held_nxt[lvl_q] = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // CONO is applied last so that clear-PI overrides the cycle logic above.
        if (bus.cono) begin
            if (bus.cono_e[23]) begin
                on_nxt    = '0;
                held_nxt  = '0;
                preq_nxt  = '0;
                act_nxt   = 1'b0;
                req_nxt   = 1'b0;
                busy_nxt  = 1'b0;
                level_nxt = 3'd0;
                state_nxt = IDLE;
            end
`ifdef KV10_PI_PROGREQ_EN
            if (bus.cono_e[22]) preq_nxt = preq_nxt & ~sel;
            if (bus.cono_e[24]) preq_nxt = preq_nxt | sel;
`endif
            if (bus.cono_e[25]) on_nxt = on_nxt | sel;
            if (bus.cono_e[26]) on_nxt = on_nxt & ~sel;
            if (bus.cono_e[27]) act_nxt = 1'b0;
            if (bus.cono_e[28]) act_nxt = 1'b1;
        end

`ifndef KV10_PI_PROGREQ_EN
        preq_nxt = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            on_q    <= '0;
            held_q  <= '0;
            preq_q  <= '0;
            act_q   <= 1'b0;
            lvl_q   <= 3'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            level_q <= 3'd0;
            addr_q  <= '0;
        end else begin
            state   <= state_nxt;
            on_q    <= on_nxt;
            held_q  <= held_nxt;
            preq_q  <= preq_nxt;
            act_q   <= act_nxt;
            lvl_q   <= lvl_nxt;
            req_q   <= req_nxt;
            busy_q  <= busy_nxt;
            level_q <= level_nxt;
            addr_q  <= addr_nxt;
        end
    end

    assign bus.pi_req   = req_q;
    assign bus.pi_level = level_q;
    assign bus.pi_addr  = addr_q;
    assign bus.pi_busy  = busy_q;
    assign bus.coni     = {11'b0, preq_q, 3'b0, held_q, act_q, on_q};
endmodule

// File: tb/tb_pi_controller.sv
// Directed self-checking bench for pi_controller; expected values are hand-computed
// from the level/vector arithmetic (vector = 'o40 + 2*level, CONI field placement).
module tb_pi_controller;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pi_controller_if #(.ADDR_W(18)) bus ();

    pi_controller #(.INT_BASE('o40), .ADDR_W(18)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold the given strobes for exactly one clock edge, then return at the next falling edge.
    task automatic applyStimulus(input logic do_cono, input logic [17:0] e, input logic dis,
                                 input logic ack, input logic done, input logic hold,
                                 input logic second);
        bus.cono       = do_cono;
        bus.cono_e     = e;
        bus.dismiss    = dis;
        bus.cpu_ack    = ack;
        bus.int_done   = done;
        bus.int_hold   = hold;
        bus.int_second = second;
        @(negedge clk);
        bus.cono       = 1'b0;
        bus.cono_e     = '0;
        bus.dismiss    = 1'b0;
        bus.cpu_ack    = 1'b0;
        bus.int_done   = 1'b0;
        bus.int_hold   = 1'b0;
        bus.int_second = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.dev_req    = '0;
        bus.cono       = 1'b0;
        bus.cono_e     = '0;
        bus.dismiss    = 1'b0;
        bus.cpu_ack    = 1'b0;
        bus.int_done   = 1'b0;
        bus.int_hold   = 1'b0;
        bus.int_second = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("reset_req",   64'(bus.pi_req),   64'd0);
        checkOutput("reset_level", 64'(bus.pi_level), 64'd0);
        checkOutput("reset_addr",  64'(bus.pi_addr),  64'd0);
        checkOutput("reset_busy",  64'(bus.pi_busy),  64'd0);
        checkOutput("reset_coni",  64'(bus.coni),     64'd0);
        reset = 1'b0;

        $display("[TB] enable all levels and activate");
        applyStimulus(1'b1, 18'o2377, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("enable_coni", 64'(bus.coni), 64'h0FF);

        bus.dev_req = 7'b0010000;
        @(negedge clk);
        checkOutput("lvl3_req",   64'(bus.pi_req),   64'd1);
        checkOutput("lvl3_level", 64'(bus.pi_level), 64'd3);
        checkOutput("lvl3_addr",  64'(bus.pi_addr),  64'o46);

        bus.dev_req = '0;
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lvl3_ack_busy", 64'(bus.pi_busy), 64'd1);
        checkOutput("lvl3_ack_req",  64'(bus.pi_req),  64'd0);
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("lvl3_hold_busy", 64'(bus.pi_busy), 64'd0);
        checkOutput("lvl3_hold_coni", 64'(bus.coni),    64'h10FF);

        $display("[TB] held level 3 masks level 5 but not level 2");
        bus.dev_req = 7'b0000100;
        @(negedge clk);
        checkOutput("masked_lvl5_req", 64'(bus.pi_req), 64'd0);
        bus.dev_req = 7'b0100100;
        @(negedge clk);
        checkOutput("lvl2_req",   64'(bus.pi_req),   64'd1);
        checkOutput("lvl2_level", 64'(bus.pi_level), 64'd2);
        checkOutput("lvl2_addr",  64'(bus.pi_addr),  64'o44);
        bus.dev_req = '0;
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("lvl2_auto_busy", 64'(bus.pi_busy), 64'd0);
        checkOutput("lvl2_auto_coni", 64'(bus.coni),    64'h10FF);
        applyStimulus(1'b0, 18'o0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("dismiss3_coni", 64'(bus.coni), 64'h0FF);

        $display("[TB] level 1 preempts pending level 4");
        bus.dev_req = 7'b0001000;
        @(negedge clk);
        checkOutput("lvl4_level", 64'(bus.pi_level), 64'd4);
        checkOutput("lvl4_addr",  64'(bus.pi_addr),  64'o50);
        bus.dev_req = 7'b1001000;
        @(negedge clk);
        checkOutput("preempt_level", 64'(bus.pi_level), 64'd1);
        checkOutput("preempt_addr",  64'(bus.pi_addr),  64'o42);
        bus.dev_req = '0;
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("lvl1_held_coni", 64'(bus.coni), 64'h40FF);
        applyStimulus(1'b0, 18'o0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("dismiss1_coni", 64'(bus.coni), 64'h0FF);

        $display("[TB] second-location cycle on level 6");
        bus.dev_req = 7'b0000010;
        @(negedge clk);
        checkOutput("lvl6_addr", 64'(bus.pi_addr), 64'o54);
        bus.dev_req = '0;
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("lvl6_second_addr", 64'(bus.pi_addr), 64'o55);
        checkOutput("lvl6_second_busy", 64'(bus.pi_busy), 64'd1);
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("lvl6_done_busy", 64'(bus.pi_busy), 64'd0);
        checkOutput("lvl6_done_coni", 64'(bus.coni),    64'h0FF);

        $display("[TB] hold levels 5 and 2, then dismiss three times");
        bus.dev_req = 7'b0000100;
        @(negedge clk);
        bus.dev_req = '0;
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        bus.dev_req = 7'b0100000;
        @(negedge clk);
        checkOutput("lvl2_over_held5_level", 64'(bus.pi_level), 64'd2);
        bus.dev_req = '0;
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("held25_coni", 64'(bus.coni), 64'h24FF);
        applyStimulus(1'b0, 18'o0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("dismiss_a_coni", 64'(bus.coni), 64'h04FF);
        applyStimulus(1'b0, 18'o0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("dismiss_b_coni", 64'(bus.coni), 64'h0FF);
        applyStimulus(1'b0, 18'o0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("dismiss_c_coni", 64'(bus.coni), 64'h0FF);

        $display("[TB] clear PI in the middle of a cycle");
        bus.dev_req = 7'b0010000;
        @(negedge clk);
        applyStimulus(1'b0, 18'o0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_clear_busy", 64'(bus.pi_busy), 64'd1);
        applyStimulus(1'b1, 18'o10000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_busy", 64'(bus.pi_busy), 64'd0);
        checkOutput("clear_coni", 64'(bus.coni),    64'd0);
        @(negedge clk);
        checkOutput("inactive_req", 64'(bus.pi_req), 64'd0);
        bus.dev_req = '0;

        applyStimulus(1'b1, 18'o4177, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef KV10_PI_PROGREQ_EN
        checkOutput("preq_set_coni", 64'(bus.coni), 64'h1FC0000);
`else
        checkOutput("preq_ignored_coni", 64'(bus.coni), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
